// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions for the pipeline controller: bus widths, control
// register indices, MEM-stage control opcodes, exception codes and the
// controller state encoding.
package pipe_ctrl_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int CTRL_OP_W   = 2;
  localparam int ISA_EXP_W   = 3;

  typedef enum logic [CTRL_OP_W-1:0] {
    CTRL_OP_NOP  = 2'd0,
    CTRL_OP_WRCR = 2'd1,
    CTRL_OP_EXRT = 2'd2
  } ctrl_op_e;

  localparam logic [ISA_EXP_W-1:0] ISA_EXP_NONE    = 3'd0;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT = 3'd1;

  localparam logic [REG_ADDR_W-1:0] CREG_STATUS     = 5'd0;
  localparam logic [REG_ADDR_W-1:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [REG_ADDR_W-1:0] CREG_CAUSE      = 5'd2;
  localparam logic [REG_ADDR_W-1:0] CREG_EXC_VEC    = 5'd3;
  localparam logic [REG_ADDR_W-1:0] CREG_EPC        = 5'd4;

  // Status register layout: bit1 = kernel mode, bit0 = interrupt enable.
  localparam logic [1:0] STATUS_RESET = 2'b10;
  localparam logic [1:0] STATUS_EXC   = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  // True for indices that map onto a real control register.
  function automatic logic creg_exists(input logic [REG_ADDR_W-1:0] idx);
    return idx <= CREG_EPC;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline controller bus: hazard/busy inputs, MEM-stage event inputs,
// control register read port and the per-stage stall/flush outputs.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                   IFBusy;
  logic                   MemBusy;
  logic                   LdHazard;
  logic                   MEMEn;
  logic                   MEMBrFlag;
  logic [WORD_ADDR_W-1:0] MEMPC;
  logic [CTRL_OP_W-1:0]   MEMCtrlOp;
  logic [ISA_EXP_W-1:0]   MEMExpCode;
  logic [REG_ADDR_W-1:0]  MEMDstAddr;
  logic [WORD_DATA_W-1:0] MEMWrData;
  logic                   IRQ;
  logic [REG_ADDR_W-1:0]  CRAddr;
  logic [WORD_DATA_W-1:0] CRRdData;
  logic                   IFStall;
  logic                   IDStall;
  logic                   EXStall;
  logic                   MEMStall;
  logic                   IFFlush;
  logic                   IDFlush;
  logic                   EXFlush;
  logic                   MEMFlush;
  logic [WORD_ADDR_W-1:0] NewPC;
  logic                   ExeMode;

  // Pipeline side: drives the status/event inputs, receives control.
  modport master (
    output IFBusy, MemBusy, LdHazard, MEMEn, MEMBrFlag, MEMPC, MEMCtrlOp,
           MEMExpCode, MEMDstAddr, MEMWrData, IRQ, CRAddr,
    input  CRRdData, IFStall, IDStall, EXStall, MEMStall,
           IFFlush, IDFlush, EXFlush, MEMFlush, NewPC, ExeMode
  );

  // Controller side.
  modport slave (
    input  IFBusy, MemBusy, LdHazard, MEMEn, MEMBrFlag, MEMPC, MEMCtrlOp,
           MEMExpCode, MEMDstAddr, MEMWrData, IRQ, CRAddr,
    output CRRdData, IFStall, IDStall, EXStall, MEMStall,
           IFFlush, IDFlush, EXFlush, MEMFlush, NewPC, ExeMode
  );

endinterface

// File: rtl/pipe_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous interrupt line into clk.
module pipe_ctrl_sync2 (
  input  logic clk,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; q is the metastability-safe copy.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush generation, exception and return
// sequencing, and the kernel control register file (status, pre-status,
// cause, exception vector, EPC).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] EXC_VEC_INIT = 30'h0000_0100
) (
  input  logic          clk,
  input  logic          reset_,
  pipe_ctrl_if.slave    bus
);

  state_e                 state;
  logic [1:0]             cr_status;
  logic [1:0]             cr_pre_status;
  logic [ISA_EXP_W-1:0]   cr_cause;
  logic [WORD_ADDR_W-1:0] cr_exc_vec;
  logic [WORD_ADDR_W-1:0] cr_epc;

  logic                   irq_sync;
  logic                   stall;
  logic                   event_ok;
  logic                   irq_take;
  logic                   exc_take;
  logic                   exrt_take;
  logic                   wrcr_take;
  logic                   flush;
  logic [ISA_EXP_W-1:0]   exc_cause;
  logic [WORD_ADDR_W-1:0] epc_next;
  logic [WORD_DATA_W-1:0] rd_data;
  logic [WORD_ADDR_W-1:0] new_pc;

  pipe_ctrl_sync2 u_irq_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d      (bus.IRQ),
    .q      (irq_sync)
  );

  // Qualify MEM-stage events; an interrupt is held off in REDIR so the
  // flushed slot behind a redirect cannot take it a second time.
  always_comb begin
    stall     = bus.IFBusy | bus.MemBusy;
    event_ok  = bus.MEMEn & ~stall;
    irq_take  = irq_sync & cr_status[0] & (state == ST_RUN);
    exc_take  = event_ok & ((bus.MEMExpCode != ISA_EXP_NONE) | irq_take);
    exc_cause = (bus.MEMExpCode != ISA_EXP_NONE) ? bus.MEMExpCode : ISA_EXP_EXT_INT;
    exrt_take = event_ok & ~exc_take & (bus.MEMCtrlOp == CTRL_OP_EXRT);
    wrcr_take = event_ok & ~exc_take & (bus.MEMCtrlOp == CTRL_OP_WRCR);
    flush     = ~reset_ & (exc_take | exrt_take);
    epc_next  = bus.MEMBrFlag ? (bus.MEMPC - WORD_ADDR_W'(1)) : bus.MEMPC;
  end

  // Redirect target: exception vector on an exception, EPC on a return.
  always_comb begin
    new_pc = '0;
    if (flush) begin
      new_pc = exc_take ? cr_exc_vec : cr_epc;
    end
  end

  // Control register read port, with a bypass for a write committing now.
  always_comb begin
    rd_data = '0;
    case (bus.CRAddr)
      CREG_STATUS:     rd_data = WORD_DATA_W'(cr_status);
      CREG_PRE_STATUS: rd_data = WORD_DATA_W'(cr_pre_status);
      CREG_CAUSE:      rd_data = WORD_DATA_W'(cr_cause);
      CREG_EXC_VEC:    rd_data = WORD_DATA_W'(cr_exc_vec);
      CREG_EPC:        rd_data = WORD_DATA_W'(cr_epc);
      default:         rd_data = '0;
    endcase
    if (wrcr_take && (bus.MEMDstAddr == bus.CRAddr) && creg_exists(bus.CRAddr)) begin
      rd_data = bus.MEMWrData;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.IFStall  = stall | bus.LdHazard;
    bus.IDStall  = stall;
    bus.EXStall  = stall;
    bus.MEMStall = stall;
    bus.IFFlush  = flush;
    bus.IDFlush  = flush | bus.LdHazard;
    bus.EXFlush  = flush;
    bus.MEMFlush = flush;
    bus.NewPC    = new_pc;
    bus.CRRdData = rd_data;
    bus.ExeMode  = cr_status[1];
  end

  // RUN/REDIR sequencer: a redirect occupies exactly one cycle in REDIR.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state <= ST_RUN;
    end else begin
      state <= (exc_take | exrt_take) ? ST_REDIR : ST_RUN;
    end
  end

  // Control register updates: exception entry, return, or explicit write.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      cr_status     <= STATUS_RESET;
      cr_pre_status <= '0;
      cr_cause      <= '0;
      cr_exc_vec    <= EXC_VEC_INIT;
      cr_epc        <= '0;
    end else if (exc_take) begin
      cr_epc        <= epc_next;
      cr_cause      <= exc_cause;
      cr_pre_status <= cr_status;
      cr_status     <= STATUS_EXC;
    end else if (exrt_take) begin
      cr_status     <= cr_pre_status;
    end else if (wrcr_take) begin
      case (bus.MEMDstAddr)
        CREG_STATUS:     cr_status     <= bus.MEMWrData[1:0];
        CREG_PRE_STATUS: cr_pre_status <= bus.MEMWrData[1:0];
        CREG_CAUSE:      cr_cause      <= bus.MEMWrData[ISA_EXP_W-1:0];
        CREG_EXC_VEC:    cr_exc_vec    <= bus.MEMWrData[WORD_ADDR_W-1:0];
        CREG_EPC:        cr_epc        <= bus.MEMWrData[WORD_ADDR_W-1:0];
        default:         ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: reset values, stall/flush decoding,
// exception entry and return, interrupt synchronisation, CR writes with
// bypass, stalled exceptions and reset during a redirect.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic reset_;
  int   n_cmp;
  int   n_err;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IFBusy     = 1'b0;
    bus.MemBusy    = 1'b0;
    bus.LdHazard   = 1'b0;
    bus.MEMEn      = 1'b0;
    bus.MEMBrFlag  = 1'b0;
    bus.MEMPC      = '0;
    bus.MEMCtrlOp  = CTRL_OP_NOP;
    bus.MEMExpCode = ISA_EXP_NONE;
    bus.MEMDstAddr = '0;
    bus.MEMWrData  = '0;
    bus.CRAddr     = '0;
  endtask

  task automatic read_cr(input logic [REG_ADDR_W-1:0] idx, output logic [WORD_DATA_W-1:0] v);
    bus.CRAddr = idx;
    #1;
    v = bus.CRRdData;
  endtask

  task automatic test_reset();
    logic [WORD_DATA_W-1:0] v;
    logic [WORD_DATA_W-1:0] exp_cr [6];
    exp_cr = '{32'h2, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      read_cr(REG_ADDR_W'(i), v);
      n_cmp++;
      if (v !== exp_cr[i]) begin
        n_err++;
        $display("[TB] FAIL reset_cr%0d: got %h expected %h", i, v, exp_cr[i]);
      end
    end
    n_cmp++;
    if ({bus.ExeMode, bus.IFFlush, bus.IFStall, bus.NewPC} !== {1'b1, 1'b0, 1'b0, 30'h0}) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %b%b%b %h expected 100 0", bus.ExeMode, bus.IFFlush, bus.IFStall, bus.NewPC);
    end
  endtask

  task automatic test_stall();
    logic [WORD_DATA_W-1:0] v;
    idle();
    bus.MemBusy    = 1'b1;
    bus.LdHazard   = 1'b1;
    bus.MEMEn      = 1'b1;
    bus.MEMExpCode = 3'd2;
    #1;
    n_cmp++;
    if ({bus.IFStall, bus.IDStall, bus.EXStall, bus.MEMStall} !== 4'b1111) begin
      n_err++;
      $display("[TB] FAIL stall_stalls: got %b expected 1111", {bus.IFStall, bus.IDStall, bus.EXStall, bus.MEMStall});
    end
    n_cmp++;
    if ({bus.IFFlush, bus.IDFlush, bus.EXFlush, bus.MEMFlush} !== 4'b0100) begin
      n_err++;
      $display("[TB] FAIL stall_flushes: got %b expected 0100", {bus.IFFlush, bus.IDFlush, bus.EXFlush, bus.MEMFlush});
    end
    tick();
    idle();
    read_cr(CREG_CAUSE, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL stall_no_cr_change: got %h expected 0", v);
    end
    // Load hazard alone stalls only IF and bubbles only ID.
    bus.LdHazard = 1'b1;
    #1;
    n_cmp++;
    if ({bus.IFStall, bus.IDStall, bus.IDFlush, bus.IFFlush} !== 4'b1010) begin
      n_err++;
      $display("[TB] FAIL ldhazard_only: got %b expected 1010", {bus.IFStall, bus.IDStall, bus.IDFlush, bus.IFFlush});
    end
    bus.LdHazard = 1'b0;
  endtask

  task automatic test_exception();
    logic [WORD_DATA_W-1:0] v;
    idle();
    bus.MEMEn      = 1'b1;
    bus.MEMExpCode = 3'd2;
    bus.MEMPC      = 30'h40;
    bus.MEMBrFlag  = 1'b1;
    #1;
    n_cmp++;
    if ({bus.IFFlush, bus.IDFlush, bus.EXFlush, bus.MEMFlush, bus.NewPC} !== {4'b1111, 30'h100}) begin
      n_err++;
      $display("[TB] FAIL exc_flush: got %b %h expected 1111 100",
               {bus.IFFlush, bus.IDFlush, bus.EXFlush, bus.MEMFlush}, bus.NewPC);
    end
    tick();
    idle();
    read_cr(CREG_EPC, v);
    n_cmp++;
    if (v !== 32'h3F) begin n_err++; $display("[TB] FAIL exc_epc: got %h expected 3f", v); end
    read_cr(CREG_CAUSE, v);
    n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("[TB] FAIL exc_cause: got %h expected 2", v); end
    read_cr(CREG_STATUS, v);
    n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("[TB] FAIL exc_status: got %h expected 2", v); end
    read_cr(CREG_PRE_STATUS, v);
    n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("[TB] FAIL exc_pre_status: got %h expected 2", v); end
  endtask

  task automatic test_exrt();
    logic [WORD_DATA_W-1:0] v;
    // Give pre-status a distinct value so the return is observable.
    idle();
    bus.MEMEn      = 1'b1;
    bus.MEMCtrlOp  = CTRL_OP_WRCR;
    bus.MEMDstAddr = CREG_PRE_STATUS;
    bus.MEMWrData  = 32'h3;
    tick();
    idle();
    bus.MEMEn     = 1'b1;
    bus.MEMCtrlOp = CTRL_OP_EXRT;
    #1;
    n_cmp++;
    if ({bus.IFFlush, bus.NewPC} !== {1'b1, 30'h3F}) begin
      n_err++;
      $display("[TB] FAIL exrt_redirect: got %b %h expected 1 3f", bus.IFFlush, bus.NewPC);
    end
    tick();
    idle();
    read_cr(CREG_STATUS, v);
    n_cmp++;
    if (v !== 32'h3) begin n_err++; $display("[TB] FAIL exrt_status: got %h expected 3", v); end
  endtask

  task automatic test_irq();
    logic [WORD_DATA_W-1:0] v;
    idle();
    tick();
    bus.MEMEn = 1'b1;
    bus.MEMPC = 30'h80;
    bus.IRQ   = 1'b1;
    #1;
    n_cmp++;
    if (bus.IFFlush !== 1'b0) begin n_err++; $display("[TB] FAIL irq_edge0: got %b expected 0", bus.IFFlush); end
    tick();
    n_cmp++;
    if (bus.IFFlush !== 1'b0) begin n_err++; $display("[TB] FAIL irq_edge1: got %b expected 0", bus.IFFlush); end
    tick();
    n_cmp++;
    if ({bus.IFFlush, bus.NewPC} !== {1'b1, 30'h100}) begin
      n_err++;
      $display("[TB] FAIL irq_edge2: got %b %h expected 1 100", bus.IFFlush, bus.NewPC);
    end
    tick();
    bus.IRQ = 1'b0;
    idle();
    read_cr(CREG_CAUSE, v);
    n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("[TB] FAIL irq_cause: got %h expected 1", v); end
    read_cr(CREG_EPC, v);
    n_cmp++;
    if (v !== 32'h80) begin n_err++; $display("[TB] FAIL irq_epc: got %h expected 80", v); end
    read_cr(CREG_STATUS, v);
    n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("[TB] FAIL irq_status: got %h expected 2", v); end
    // Interrupts disabled now: a held IRQ must be ignored.
    bus.IRQ   = 1'b1;
    bus.MEMEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.IFFlush !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL irq_masked_%0d: got %b expected 0", i, bus.IFFlush);
      end
      tick();
    end
    bus.IRQ = 1'b0;
    idle();
    repeat (3) tick();
  endtask

  task automatic test_wrcr();
    logic [WORD_DATA_W-1:0] v;
    idle();
    bus.MEMEn      = 1'b1;
    bus.MEMCtrlOp  = CTRL_OP_WRCR;
    bus.MEMDstAddr = CREG_EXC_VEC;
    bus.MEMWrData  = 32'h200;
    bus.CRAddr     = CREG_EXC_VEC;
    #1;
    n_cmp++;
    if ({bus.CRRdData, bus.IFFlush} !== {32'h200, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL wrcr_bypass: got %h %b expected 200 0", bus.CRRdData, bus.IFFlush);
    end
    tick();
    idle();
    read_cr(CREG_EXC_VEC, v);
    n_cmp++;
    if (v !== 32'h200) begin n_err++; $display("[TB] FAIL wrcr_commit: got %h expected 200", v); end
    bus.MEMEn      = 1'b1;
    bus.MEMCtrlOp  = CTRL_OP_WRCR;
    bus.MEMDstAddr = CREG_EXC_VEC;
    bus.MEMWrData  = 32'h300;
    bus.MEMExpCode = 3'd3;
    bus.MEMPC      = 30'h55;
    #1;
    n_cmp++;
    if ({bus.IFFlush, bus.NewPC, bus.CRRdData} !== {1'b1, 30'h200, 32'h200}) begin
      n_err++;
      $display("[TB] FAIL wrcr_exc_same_cycle: got %b %h %h expected 1 200 200", bus.IFFlush, bus.NewPC, bus.CRRdData);
    end
    tick();
    idle();
    read_cr(CREG_EXC_VEC, v);
    n_cmp++;
    if (v !== 32'h200) begin n_err++; $display("[TB] FAIL wrcr_suppressed: got %h expected 200", v); end
    read_cr(CREG_CAUSE, v);
    n_cmp++;
    if (v !== 32'h3) begin n_err++; $display("[TB] FAIL wrcr_exc_cause: got %h expected 3", v); end
  endtask

  task automatic test_busy_exc();
    logic [WORD_DATA_W-1:0] v;
    idle();
    tick();
    bus.MEMEn      = 1'b1;
    bus.MEMExpCode = 3'd5;
    bus.MEMPC      = 30'h10;
    bus.MemBusy    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.IFFlush, bus.MEMStall} !== 2'b01) begin
        n_err++;
        $display("[TB] FAIL busy_hold_%0d: got %b expected 01", i, {bus.IFFlush, bus.MEMStall});
      end
      tick();
    end
    read_cr(CREG_CAUSE, v);
    n_cmp++;
    if (v !== 32'h3) begin n_err++; $display("[TB] FAIL busy_cause_held: got %h expected 3", v); end
    bus.MemBusy = 1'b0;
    #1;
    n_cmp++;
    if ({bus.IFFlush, bus.NewPC} !== {1'b1, 30'h200}) begin
      n_err++;
      $display("[TB] FAIL busy_release: got %b %h expected 1 200", bus.IFFlush, bus.NewPC);
    end
    tick();
    read_cr(CREG_CAUSE, v);
    n_cmp++;
    if (v !== 32'h5) begin n_err++; $display("[TB] FAIL busy_cause: got %h expected 5", v); end
    // Now in REDIR: pulse reset with an exception still presented.
    reset_ = 1'b1;
    #1;
    n_cmp++;
    if ({bus.IFFlush, bus.NewPC} !== {1'b0, 30'h0}) begin
      n_err++;
      $display("[TB] FAIL redir_reset_out: got %b %h expected 0 0", bus.IFFlush, bus.NewPC);
    end
    idle();
    test_reset();
    @(negedge clk);
    reset_ = 1'b0;
    tick();
    read_cr(CREG_EXC_VEC, v);
    n_cmp++;
    if (v !== 32'h100) begin n_err++; $display("[TB] FAIL post_reset_vec: got %h expected 100", v); end
  endtask

  // Run the scenarios in order and report.
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_  = 1'b1;
    bus.IRQ = 1'b0;
    idle();
    tick();
    tick();
    test_reset();
    @(negedge clk);
    reset_ = 1'b0;
    tick();
    test_stall();
    test_exception();
    test_exrt();
    test_irq();
    test_wrcr();
    test_busy_exc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VEC_INIT, default 30'h0000_0100, reset value of the exception vector register (CR3).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset_  in  1  reset, asynchronous, active-high.
REQ-004 IFBusy, MemBusy  in  1 each  fetch / memory access not complete.
REQ-005 LdHazard  in  1  load-use hazard from decoder.
REQ-006 MEMEn, MEMBrFlag  in  1 each  MEM-stage valid; MEM instruction sits in a branch delay slot.
REQ-007 MEMPC  in  `WORD_ADDR_W  MEM-stage word PC.
REQ-008 MEMCtrlOp  in  `CTRL_OP_W  NOP=0, WRCR=1, EXRT=2.
REQ-009 MEMExpCode  in  `ISA_EXP_W  0 = none, 1 = external interrupt, 2..7 = synchronous causes.
REQ-010 MEMDstAddr  in  `REG_ADDR_W  CR index for WRCR; MEMWrData  in  `WORD_DATA_W  CR write data.
REQ-011 IRQ  in  1  asynchronous level interrupt request.
REQ-012 CRAddr  in  `REG_ADDR_W, CRRdData  out  `WORD_DATA_W  combinational CR read port for ID.
REQ-013 IFStall, IDStall, EXStall, MEMStall  out  1 each  per-stage register hold.
REQ-014 IFFlush, IDFlush, EXFlush, MEMFlush  out  1 each  per-stage bubble insert.
REQ-015 NewPC  out  `WORD_ADDR_W  redirect target, valid while IFFlush=1; ExeMode  out  1  1 = kernel.

Function
REQ-016 Stall = IFBusy | MemBusy; IDStall = EXStall = MEMStall = Stall; IFStall = Stall | LdHazard; all combinational.
REQ-017 IDFlush = Flush | LdHazard; IFFlush = EXFlush = MEMFlush = Flush.
REQ-018 CRs: CR0 status {bit1 ExeMode, bit0 IE}; CR1 pre-status; CR2 cause (3 bits, zero-extended); CR3 vector; CR4 EPC; other indices read 0, writes ignored.
REQ-019 IRQ passes a 2-flop synchronizer; IrqSync is the second flop.
REQ-020 Event qualification: an event is evaluated only when MEMEn=1 and Stall=0; with Stall=1 nothing is taken and no CR changes.
REQ-021 Exception taken when MEMExpCode!=0, or when IrqSync=1 and IE=1 (cause 1); synchronous cause wins over IRQ in the same cycle.
REQ-022 On exception, same cycle: Flush=1, NewPC=CR3; next edge: CR4=MEMBrFlag ? MEMPC-1 : MEMPC (mod 2^30), CR2=cause, CR1=CR0, CR0={1,0}.
REQ-023 EXRT (no exception): Flush=1, NewPC=CR4; next edge CR0=CR1.
REQ-024 WRCR (no exception): next edge CR[MEMDstAddr]=MEMWrData truncated to CR width; no flush; exception same cycle suppresses the write.
REQ-025 CRRdData bypass: when a WRCR to CRAddr commits this cycle, CRRdData returns MEMWrData.
REQ-026 State machine RUN/REDIR: RUN->REDIR on exception or EXRT; REDIR->RUN unconditionally next cycle; in REDIR IRQ not taken (blocks double-take on the flushed slot).
REQ-027 ExeMode = CR0 bit1.

Reset
REQ-028 On reset_ high, immediately: state=RUN, CR0=2'b10, CR1=0, CR2=0, CR3=EXC_VEC_INIT, CR4=0, synchronizer=0; Flush=0, NewPC=0.
REQ-029 Reset mid-redirect abandons the redirect; first post-reset cycle is RUN.

Structure
REQ-030 CR indices, CTRL_OP codes, ISA_EXP codes, state encodings belong in the shared cpu header.
REQ-031 One sub-module: sync2 (2-flop synchronizer) for IRQ.

Verification
REQ-032 MemBusy=1, LdHazard=1 -> all four stalls 1, IDFlush=1, other flushes 0, no CR change.
REQ-033 MEMEn=1, MEMExpCode=2, MEMPC=30'h40, MEMBrFlag=1 -> Flush=1, NewPC=30'h100; next edge CR4=30'h3F, CR2=2, CR0=2'b10, CR1=2'b10.
REQ-034 Then EXRT -> NewPC=30'h3F, Flush=1; CR0 restored to CR1.
REQ-035 IE=1, IRQ raised -> exception cause 1 no earlier than 2 edges later; IRQ with IE=0 -> no action.
REQ-036 WRCR CR3=0x200 with CRAddr=3 -> CRRdData=0x200 same cycle; WRCR with MEMExpCode=3 -> CR3 unchanged, cause 3.
REQ-037 Exception with MemBusy=1 held 3 cycles -> taken on first cycle MemBusy=0; reset_ pulse during REDIR -> CRs at reset values.
